fifo_level: RTL and testbench

Parametrised synchronous FIFO with occupancy tracking, programmable almost-full/almost-empty thresholds, guarded push/pop, synchronous flush and sticky error flags. Drop-in successor to the basic queue used between host-interface byte streams and the memory-programmer command engine. It removes the need for callers to gate `push`/`pop` against `full`/`empty` themselves, and it lets producers throttle early.

---
 rtl/fifo_pkg.sv | 32 +++
 rtl/fifo_level_if.sv | 33 +++
 rtl/fifo_level_ctrl.sv | 133 +++++++++++++
 rtl/fifo_level.sv | 59 +++++
 tb/tb_fifo_level.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for fifo_level: parameter-legality helpers evaluated at
// elaboration time and the per-cycle operation encoding used by the control block.
package fifo_pkg;

    // Accepted operation in a cycle, encoded as {push_accepted, pop_accepted}.
    typedef enum logic [1:0] {
        OpNone = 2'b00,
        OpPop  = 2'b01,
        OpPush = 2'b10,
        OpBoth = 2'b11
    } fifo_op_e;

    // Depth must be a power of two so the low pointer bits wrap on their own.
    function automatic bit depth_ok(int unsigned num_words);
        return (num_words >= 2) && ((num_words & (num_words - 1)) == 0);
    endfunction

    function automatic bit afull_ok(int unsigned afull_level, int unsigned num_words);
        return (afull_level >= 1) && (afull_level <= num_words);
    endfunction

    function automatic bit aempty_ok(int unsigned aempty_level, int unsigned num_words);
        return aempty_level <= (num_words - 1);
    endfunction

    function automatic bit params_ok(int unsigned num_words, int unsigned afull_level,
                                     int unsigned aempty_level);
        return depth_ok(num_words) && afull_ok(afull_level, num_words)
            && aempty_ok(aempty_level, num_words);
    endfunction

endpackage

// File: rtl/fifo_level_if.sv
// Handshake and status bundle between a producer/consumer and fifo_level.
// The master drives requests and data; the slave (the FIFO) drives head data and status.
interface fifo_level_if #(
    parameter int unsigned BUS_WIDTH = 8,
    parameter int unsigned NUM_WORDS = 8
);
    localparam int unsigned AW = $clog2(NUM_WORDS);

    logic                 flush;
    logic                 push;
    logic                 pop;
    logic [BUS_WIDTH-1:0] din;
    logic                 clear_err;
    logic [BUS_WIDTH-1:0] dout;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [AW:0]          level;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output flush, push, pop, din, clear_err,
        input  dout, full, empty, almost_full, almost_empty, level, overflow, underflow
    );

    modport slave (
        input  flush, push, pop, din, clear_err,
        output dout, full, empty, almost_full, almost_empty, level, overflow, underflow
    );

endinterface

// File: rtl/fifo_level_ctrl.sv
// fifo_level control: pointers, occupancy counter, accept guards, status flags and
// sticky error flags. Sticky flags exist only when FIFO_LEVEL_ERR_FLAGS_EN is defined.
module fifo_level_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned NUM_WORDS    = 8,
    parameter int unsigned AFULL_LEVEL  = NUM_WORDS - 2,
    parameter int unsigned AEMPTY_LEVEL = 2,
    localparam int unsigned AW          = $clog2(NUM_WORDS),
    localparam int unsigned LW          = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_err_i,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [AW-1:0] rd_addr_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          almost_full_o,
    output logic          almost_empty_o,
    output logic [AW:0]   level_o,
    output logic          overflow_o,
    output logic          underflow_o
);

    localparam logic [AW:0] LevelFull  = LW'(NUM_WORDS);
    localparam logic [AW:0] LevelAfull = LW'(AFULL_LEVEL);
    localparam logic [AW:0] LevelAempt = LW'(AEMPTY_LEVEL);
    localparam logic [AW:0] PtrOne     = LW'(1);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic        pop_acc;
    logic        push_acc;
    fifo_op_e    op;

    // Status decodes registered occupancy only, never the requests.
    assign full_o         = (level_q == LevelFull);
    assign empty_o        = (level_q == '0);
    assign almost_full_o  = (level_q >= LevelAfull);
    assign almost_empty_o = (level_q <= LevelAempt);
    assign level_o        = level_q;
    assign wr_addr_o      = wr_ptr_q[AW-1:0];
    assign rd_addr_o      = rd_ptr_q[AW-1:0];

    // Accept guards on pre-edge state; a full FIFO takes a push only alongside a pop.
    always_comb begin
        pop_acc  = pop_i & ~empty_o;
        push_acc = push_i & (~full_o | pop_acc);
        op       = fifo_op_e'({push_acc, pop_acc});
        wr_en_o  = push_acc & ~flush_i & ~reset;
    end

    // Next pointers and occupancy; flush overrides any push/pop this cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            unique case (op)
                OpPush: begin
                    wr_ptr_d = wr_ptr_q + PtrOne;
                    level_d  = level_q + PtrOne;
                end
                OpPop: begin
                    rd_ptr_d = rd_ptr_q + PtrOne;
                    level_d  = level_q - PtrOne;
                end
                OpBoth: begin
                    wr_ptr_d = wr_ptr_q + PtrOne;
                    rd_ptr_d = rd_ptr_q + PtrOne;
                end
                default: ;
            endcase
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

`ifdef FIFO_LEVEL_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;
    logic ovf_set, unf_set;

    // A new error in the same cycle as clear_err keeps the flag set.
    always_comb begin
        ovf_set     = push_i & ~push_acc & ~flush_i;
        unf_set     = pop_i & ~pop_acc & ~flush_i;
        overflow_d  = (overflow_q & ~clear_err_i) | ovf_set;
        underflow_d = (underflow_q & ~clear_err_i) | unf_set;
    end

    // Sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`else
    logic unused_clear_err;
    assign unused_clear_err = clear_err_i;
    assign overflow_o       = 1'b0;
    assign underflow_o      = 1'b0;
`endif

endmodule

// File: rtl/fifo_level.sv
// fifo_level top: first-word-fall-through FIFO storage and head mux around
// fifo_level_ctrl. Optional sticky error flags: define FIFO_LEVEL_ERR_FLAGS_EN.
module fifo_level
    import fifo_pkg::*;
#(
    parameter int unsigned BUS_WIDTH    = 8,
    parameter int unsigned NUM_WORDS    = 8,
    parameter int unsigned AFULL_LEVEL  = NUM_WORDS - 2,
    parameter int unsigned AEMPTY_LEVEL = 2,
    localparam int unsigned AW          = $clog2(NUM_WORDS)
) (
    input logic        clk,
    input logic        reset,
    fifo_level_if.slave bus
);

    if (!params_ok(NUM_WORDS, AFULL_LEVEL, AEMPTY_LEVEL)) begin : g_bad_params
        $error("fifo_level: illegal NUM_WORDS/AFULL_LEVEL/AEMPTY_LEVEL combination");
    end

    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [AW-1:0]        rd_addr;
    logic [BUS_WIDTH-1:0] mem_q [NUM_WORDS];

    fifo_level_ctrl #(
        .NUM_WORDS   (NUM_WORDS),
        .AFULL_LEVEL (AFULL_LEVEL),
        .AEMPTY_LEVEL(AEMPTY_LEVEL)
    ) u_ctrl (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (bus.flush),
        .push_i        (bus.push),
        .pop_i         (bus.pop),
        .clear_err_i   (bus.clear_err),
        .wr_en_o       (wr_en),
        .wr_addr_o     (wr_addr),
        .rd_addr_o     (rd_addr),
        .full_o        (bus.full),
        .empty_o       (bus.empty),
        .almost_full_o (bus.almost_full),
        .almost_empty_o(bus.almost_empty),
        .level_o       (bus.level),
        .overflow_o    (bus.overflow),
        .underflow_o   (bus.underflow)
    );

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= bus.din;
        end
    end

    // Head of queue is a combinational read, so a full push+pop still shows the old head.
    assign bus.dout = mem_q[rd_addr];

endmodule

// File: tb/tb_fifo_level.sv
// Self-checking bench for fifo_level: a constant vector table for fill/drain plus
// hand sequences for overflow, full push+pop, empty push+pop, wrap, flush and reset.
module tb_fifo_level;

`ifdef FIFO_LEVEL_ERR_FLAGS_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fifo_level_if #(.BUS_WIDTH(8), .NUM_WORDS(8)) bus ();

    fifo_level #(
        .BUS_WIDTH   (8),
        .NUM_WORDS   (8),
        .AFULL_LEVEL (6),
        .AEMPTY_LEVEL(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       push;
        logic       pop;
        logic [7:0] din;
        int         lvl;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
    } vec_t;

    vec_t       tbl [16];
    logic [7:0] sb [$];
    bit         m_ovf;
    bit         m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at the negedge, model the edge, check status 1 time unit after it.
    task automatic step(input logic r, input logic p, input logic q, input logic f,
                        input logic c, input logic [7:0] d);
        bit pa;
        bit wa;
        int lvl;
        reset         = r;
        bus.push      = p;
        bus.pop       = q;
        bus.flush     = f;
        bus.clear_err = c;
        bus.din       = d;
        if (r) begin
            sb.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (f) begin
            sb.delete();
            m_ovf = m_ovf && !c;
            m_unf = m_unf && !c;
        end else begin
            pa = q && (sb.size() > 0);
            wa = p && ((sb.size() < 8) || pa);
            if (pa) begin
                chk("dout_order", {24'h0, bus.dout}, {24'h0, sb[0]});
                void'(sb.pop_front());
            end
            if (wa) sb.push_back(d);
            m_ovf = ErrEn && ((m_ovf && !c) || (p && !wa));
            m_unf = ErrEn && ((m_unf && !c) || (q && !pa));
        end
        @(posedge clk);
        #1;
        lvl = sb.size();
        chk("level", 32'(bus.level), 32'(lvl));
        chk("full", 32'(bus.full), 32'(lvl == 8));
        chk("empty", 32'(bus.empty), 32'(lvl == 0));
        chk("almost_full", 32'(bus.almost_full), 32'(lvl >= 6));
        chk("almost_empty", 32'(bus.almost_empty), 32'(lvl <= 2));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("underflow", 32'(bus.underflow), 32'(m_unf));
        @(negedge clk);
    endtask

    initial begin
        // push, pop, din, level, full, empty, almost_full, almost_empty
        tbl[0]  = '{1'b1, 1'b0, 8'h10, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 8'h11, 2, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 8'h12, 3, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h13, 4, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'h14, 5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 8'h15, 6, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8'h16, 7, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 8'h17, 8, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 8'h00, 7, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'h00, 6, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 8'h00, 5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 8'h00, 4, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 8'h00, 3, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 8'h00, 2, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1};

        reset         = 1'b1;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.flush     = 1'b0;
        bus.clear_err = 1'b0;
        bus.din       = 8'h00;
        m_ovf         = 1'b0;
        m_unf         = 1'b0;
        @(negedge clk);

        // Reset state.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_underflow", 32'(bus.underflow), 32'd0);

        // Fill 0x10..0x17 then drain in order.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, tbl[i].push, tbl[i].pop, 1'b0, 1'b0, tbl[i].din);
            chk($sformatf("tbl%0d_level", i), 32'(bus.level), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_full", i), 32'(bus.full), 32'(tbl[i].full));
            chk($sformatf("tbl%0d_empty", i), 32'(bus.empty), 32'(tbl[i].empty));
            chk($sformatf("tbl%0d_af", i), 32'(bus.almost_full), 32'(tbl[i].af));
            chk($sformatf("tbl%0d_ae", i), 32'(bus.almost_empty), 32'(tbl[i].ae));
        end

        // Overflow while full, then clear.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h10 + i));
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
        chk("ovf_set", 32'(bus.overflow), 32'(ErrEn));
        chk("ovf_level", 32'(bus.level), 32'd8);
        chk("ovf_head", {24'h0, bus.dout}, 32'h10);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);

        // Push+pop while full: slot reuse, head advances.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
        chk("both_full_level", 32'(bus.level), 32'd8);
        chk("both_full_head", {24'h0, bus.dout}, 32'h11);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        // Push+pop while empty: pop ignored, push kept.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
        chk("empty_both_unf", 32'(bus.underflow), 32'(ErrEn));
        chk("empty_both_level", 32'(bus.level), 32'd1);
        chk("empty_both_dout", {24'h0, bus.dout}, 32'h3C);

        // Fill to 5, wrap pointers three times, then flush with push asserted.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h44 + i));
            chk("wrap_level", 32'(bus.level), 32'd5);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hEE);
        chk("flush_level", 32'(bus.level), 32'd0);
        chk("flush_empty", 32'(bus.empty), 32'd1);
        chk("flush_unf_kept", 32'(bus.underflow), 32'(ErrEn));

        // Reset mid-stream at level 4 with overflow set.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h60 + i));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("pre_rst_level", 32'(bus.level), 32'd4);
        chk("pre_rst_ovf", 32'(bus.overflow), 32'(ErrEn));
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("post_rst_level", 32'(bus.level), 32'd0);
        chk("post_rst_ovf", 32'(bus.overflow), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h99);
        chk("post_rst_dout", {24'h0, bus.dout}, 32'h99);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
